// File: rtl/mac_window.sv
// Pipelined multi-lane signed dot-product engine: streams len beats of LANES pairs, accumulates
// them at full precision and presents a wrapped or saturated ACC_W result with an overflow flag.
module mac_window #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 6,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned LEN_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [LEN_W-1:0]          len_i,
  input  logic                      sat_en_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [LANES*DATA_W-1:0]   a_bus_i,
  input  logic [LANES*DATA_W-1:0]   b_bus_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [ACC_W-1:0]          f_o,
  output logic                      ovf_o,
  output logic                      busy_o
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = PROD_W + $clog2(LANES);
  localparam int unsigned WIDE_W = SUM_W + LEN_W;
  localparam int unsigned EXT_W  = ((WIDE_W > ACC_W) ? WIDE_W : ACC_W) + 1;
  localparam int unsigned TOP_W  = EXT_W - ACC_W + 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [LEN_W-1:0]         rem_q, rem_d;
  logic                     sat_q, sat_d;
  logic                     v1_q, v2_q;
  logic signed [PROD_W-1:0] prod_q [LANES];
  logic signed [PROD_W-1:0] prod_d [LANES];
  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic signed [WIDE_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0]         f_q, f_d;
  logic                     ovf_q, ovf_d;

  logic                     accept;
  logic                     job_start;
  logic signed [EXT_W-1:0]  acc_ext;
  logic [TOP_W-1:0]         acc_top;
  logic                     wide_ovf;
  logic [ACC_W-1:0]         f_res;

  assign in_ready_o  = (state_q == StRun) && (rem_q != '0);
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q != StIdle);
  assign f_o         = f_q;
  assign ovf_o       = ovf_q;

  // Stage 1: full-precision lane products.
  always_comb begin
    for (int k = 0; k < int'(LANES); k++) begin
      prod_d[k] = PROD_W'($signed(a_bus_i[k*DATA_W +: DATA_W]))
                * PROD_W'($signed(b_bus_i[k*DATA_W +: DATA_W]));
    end
  end

  // Stage 2: lane sum with clog2(LANES) guard bits.
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      sum_d = sum_d + SUM_W'(prod_q[k]);
    end
  end

  // Stage 3: wide accumulator, cleared on every job start.
  always_comb begin
    acc_d = acc_q;
    if (job_start) begin
      acc_d = '0;
    end else if (v2_q) begin
      acc_d = acc_q + WIDE_W'(sum_q);
    end
  end

  // Result fits signed ACC_W only if all bits from ACC_W-1 upward agree.
  always_comb begin
    acc_ext  = EXT_W'(acc_q);
    acc_top  = acc_ext[EXT_W-1:ACC_W-1];
    wide_ovf = !((&acc_top) || !(|acc_top));
    f_res    = acc_ext[ACC_W-1:0];
    if (wide_ovf && sat_q) begin
      f_res = acc_ext[EXT_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    sat_d     = sat_q;
    f_d       = f_q;
    ovf_d     = ovf_q;
    job_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          job_start = 1'b1;
          sat_d     = sat_en_i;
          rem_d     = len_i;
          if (len_i == '0) begin
            state_d = StDone;
            f_d     = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (accept) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Both pipeline stages empty means the last accumulator update has landed.
        if (!v1_q && !v2_q) begin
          state_d = StDone;
          f_d     = f_res;
          ovf_d   = wide_ovf;
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rem_q   <= '0;
      sat_q   <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      sum_q   <= '0;
      acc_q   <= '0;
      f_q     <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < int'(LANES); k++) begin
        prod_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sat_q   <= sat_d;
      v1_q    <= accept;
      v2_q    <= v1_q;
      acc_q   <= acc_d;
      f_q     <= f_d;
      ovf_q   <= ovf_d;
      if (v1_q) begin
        sum_q <= sum_d;
      end
      if (accept) begin
        for (int k = 0; k < int'(LANES); k++) begin
          prod_q[k] <= prod_d[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_window.sv
// Scoreboard bench for mac_window: expected results are queued at job start and compared
// when the DUT presents its result.
module tb_mac_window;

  localparam int DATA_W = 32;
  localparam int LANES  = 6;
  localparam int ACC_W  = 32;
  localparam int LEN_W  = 8;

  logic                    clk;
  logic                    rst_n;
  logic                    start;
  logic [LEN_W-1:0]        len;
  logic                    sat_en;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] a_bus;
  logic [LANES*DATA_W-1:0] b_bus;
  logic                    out_valid;
  logic                    out_ready;
  logic [ACC_W-1:0]        f;
  logic                    ovf;
  logic                    busy;

  int          checks;
  int          errors;
  int          cyc_cnt;
  int          a_mem [16][LANES];
  int          b_mem [16][LANES];
  logic [32:0] exp_q [$];

  mac_window #(
    .DATA_W(DATA_W),
    .LANES (LANES),
    .ACC_W (ACC_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .len_i      (len),
    .sat_en_i   (sat_en),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .a_bus_i    (a_bus),
    .b_bus_i    (b_bus),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .f_o        (f),
    .ovf_o      (ovf),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact signed sum in 128 bits, then wrap or clamp to 32 bits.
  function automatic logic [32:0] model(input int n, input bit sat);
    logic signed [127:0] w;
    logic                o;
    logic [31:0]         r;
    w = '0;
    for (int j = 0; j < n; j++) begin
      for (int l = 0; l < LANES; l++) begin
        w = w + 128'(a_mem[j][l]) * 128'(b_mem[j][l]);
      end
    end
    o = (w > 128'sd2147483647) || (w < -128'sd2147483648);
    r = w[31:0];
    if (o && sat) r = (w < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return {o, r};
  endfunction

  task automatic fill_const(input int a, input int b);
    for (int j = 0; j < 16; j++) begin
      for (int l = 0; l < LANES; l++) begin
        a_mem[j][l] = a;
        b_mem[j][l] = b;
      end
    end
  endtask

  task automatic fill_ramp();
    for (int j = 0; j < 16; j++) begin
      for (int l = 0; l < LANES; l++) begin
        a_mem[j][l] = j * LANES + l + 1;
        b_mem[j][l] = 2;
      end
    end
  endtask

  task automatic drive_beat(input int j);
    for (int l = 0; l < LANES; l++) begin
      a_bus[l*DATA_W +: DATA_W] = a_mem[j][l];
      b_bus[l*DATA_W +: DATA_W] = b_mem[j][l];
    end
  endtask

  task automatic run_job(input int n, input bit sat, input bit toggle, input bit poke,
                         input int hold);
    logic [32:0] exp;
    int          j;
    int          cyc;
    int          hs;
    int          last_edge;
    int          waitc;
    bit          acc;
    exp_q.push_back(model(n, sat));
    start  = 1'b1;
    len    = n[LEN_W-1:0];
    sat_en = sat;
    tick();
    start  = 1'b0;
    len    = 8'hA5;
    sat_en = !sat;
    j = 0; cyc = 0; hs = 0; last_edge = cyc_cnt;
    if (n > 0) begin
      check_eq("busy_run", busy, 1);
      while (j < n && cyc < 200) begin
        in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
        drive_beat(j);
        start = poke;
        acc = in_valid && in_ready;
        tick();
        cyc++;
        if (acc) begin
          j++;
          hs++;
          last_edge = cyc_cnt;
        end
      end
      in_valid = 1'b0;
      start    = 1'b0;
      check_eq("rdy_after_last", in_ready, 0);
      check_eq("handshakes", hs, n);
      waitc = 0;
      while (!out_valid && waitc < 50) begin
        tick();
        waitc++;
      end
      check_eq("latency", cyc_cnt - last_edge, 3);
    end
    check_eq("out_valid", out_valid, 1);
    exp = exp_q.pop_front();
    check_eq("F", f, exp[31:0]);
    check_eq("ovf", ovf, exp[32]);
    for (int i = 0; i < hold; i++) begin
      start = poke;
      tick();
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_F", f, exp[31:0]);
    end
    out_ready = 1'b1;
    start     = poke;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    check_eq("idle_after_hs", busy, 0);
    check_eq("valid_after_hs", out_valid, 0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    sat_en    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_bus     = '0;
    b_bus     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", in_ready, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_F", f, 0);
    check_eq("rst_ovf", ovf, 0);
    rst_n = 1'b1;

    fill_ramp();
    run_job(6, 1'b0, 1'b0, 1'b0, 0);
    fill_const(-3, 5);
    run_job(4, 1'b0, 1'b1, 1'b0, 0);
    fill_const(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    run_job(1, 1'b1, 1'b0, 1'b0, 0);
    run_job(1, 1'b0, 1'b0, 1'b0, 0);

    // Abort a five-beat job after two beats.
    fill_ramp();
    start = 1'b1;
    len   = 8'd5;
    tick();
    start = 1'b0;
    for (int j = 0; j < 2; j++) begin
      in_valid = 1'b1;
      drive_beat(j);
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_ready", in_ready, 0);
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_F", f, 0);
    check_eq("mid_rst_ovf", ovf, 0);
    #2;
    rst_n = 1'b1;
    repeat (6) tick();
    check_eq("post_rst_valid", out_valid, 0);
    check_eq("post_rst_busy", busy, 0);
    fill_const(1, 1);
    run_job(1, 1'b0, 1'b0, 1'b0, 0);

    run_job(0, 1'b0, 1'b0, 1'b0, 10);

    fill_ramp();
    run_job(6, 1'b1, 1'b0, 1'b1, 3);

    fill_const(-7, 9);
    run_job(3, 1'b0, 1'b1, 1'b1, 2);

    check_eq("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_window.md
MAC_WINDOW -- requirements
Module: mac_window

Interface
REQ-001 Parameter DATA_W, default 32, element width (signed two's complement).
REQ-002 Parameter LANES, default 6, element pairs multiplied per input beat.
REQ-003 Parameter ACC_W, default 32, result width.
REQ-004 Parameter LEN_W, default 8, width of beat-count field.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-006 clk  in  1  clock, all state on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 start  in  1  pulse, begins a dot-product job; honoured only in IDLE.
REQ-009 len  in  LEN_W  beats in the job, sampled with start.
REQ-010 sat_en  in  1  1 = saturate result, 0 = wrap modulo 2^ACC_W; sampled with start.
REQ-011 in_valid  in  1  a_bus/b_bus carry a beat.
REQ-012 in_ready  out  1  block accepts a beat this cycle.
REQ-013 a_bus, b_bus  in  LANES*DATA_W each  lane k = bits [k*DATA_W +: DATA_W].
REQ-014 out_valid  out  1  F/ovf valid.
REQ-015 out_ready  in  1  consumer takes result.
REQ-016 F  out  ACC_W  dot-product result.
REQ-017 ovf  out  1  exact result outside signed ACC_W range.
REQ-018 busy  out  1  high in any state except IDLE.

Function
REQ-019 States IDLE, RUN, DRAIN, DONE; start in IDLE with len>0 -> RUN; len=0 -> DONE with F=0, ovf=0 on the next edge.
REQ-020 RUN: in_ready=1 while beats remaining>0; beat accepted on edge where in_valid&in_ready; remaining decrements per accepted beat.
REQ-021 After the last beat is accepted: in_ready=0 on the next cycle; state -> DRAIN.
REQ-022 Pipeline: stage 1 registers LANES full-precision products (2*DATA_W); stage 2 registers the lane sum; stage 3 adds it into a wide accumulator of 2*DATA_W+clog2(LANES)+LEN_W bits, cleared on job start.
REQ-023 in_valid low in RUN inserts a bubble; each stage carries its own valid bit; bubbles do not change the accumulator.
REQ-024 DRAIN -> DONE when the final beat's stage-3 update is complete; out_valid asserts on the 3rd rising edge after the edge accepting the last beat.
REQ-025 Wrap mode: F = low ACC_W bits of the wide accumulator.
REQ-026 Saturate mode: F = wide value clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-027 ovf set in both modes when wide value is outside signed ACC_W range.
REQ-028 DONE: out_valid, F, ovf held stable until out_valid&out_ready; on that edge -> IDLE, out_valid=0.
REQ-029 start outside IDLE ignored, including same cycle as the out_ready handshake; a new job is accepted no earlier than the cycle after returning to IDLE.
REQ-030 len, sat_en changes after sampling have no effect on the running job.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, in_ready=0, out_valid=0, busy=0, F=0, ovf=0, clear all pipeline valids, counters and accumulator.
REQ-032 Reset mid-job SHALL discard the job; no partial result is presented after release.
REQ-033 First start is honoured on the first rising edge with rst_n high.

Verification
REQ-034 Defaults, len=6, all 36 pairs a=k+1, b=2 (k=0..35), in_valid constant -> F=1332, ovf=0, out_valid 3 edges after 6th beat.
REQ-035 len=4, in_valid toggling 1/0 each cycle, lanes a=-3, b=5 -> F=-360 (0xFFFFFE98), handshakes exactly 4.
REQ-036 len=1, all lanes a=b=0x7FFFFFFF, sat_en=1 -> F=0x7FFFFFFF, ovf=1; sat_en=0 -> F=0x00000006, ovf=1.
REQ-037 len=0 start -> DONE next edge, F=0; out_ready held low 10 cycles -> F/out_valid stable; then one out_ready -> IDLE.
REQ-038 rst_n low after 2 of 5 beats -> outputs zero immediately; new job len=1, a=b=1 all lanes -> F=6.
REQ-039 start pulsed during RUN and DONE -> no effect on count, F, or state sequence.
